alpha_div_iter: RTL

ALPHA_DIV_ITER -- requirements
Module: alpha_div_iter

---
 rtl/alpha_pkg.sv | 21 ++
 rtl/alpha_div_step.sv | 24 ++
 rtl/alpha_div_iter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alpha_pkg.sv
// Shared definitions for the iterative alpha divider.
//   state_e   : controller states (idle / busy / done)
//   DefDw     : default operand width
//   DefQw     : default number of fractional quotient bits
//   cnt_width : width of the step counter, clog2(qw + 1), at least 1
package alpha_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefQw = 7;

  function automatic int unsigned cnt_width(int unsigned qw);
    return (qw + 1 > 1) ? $clog2(qw + 1) : 1;
  endfunction

endpackage

// File: rtl/alpha_div_step.sv
// One restoring-division step, purely combinational.
//   rem_i      : current remainder (DW+1 bits, always < denom_i)
//   denom_i    : divisor
//   bit_o      : quotient bit produced by this step
//   rem_next_o : remainder after this step
module alpha_div_step #(
  parameter int unsigned DW = 8
) (
  input  logic [DW:0]   rem_i,
  input  logic [DW-1:0] denom_i,
  output logic          bit_o,
  output logic [DW:0]   rem_next_o
);

  logic [DW:0] t;
  logic [DW:0] denom_ext;

  // rem_i < denom_i < 2^DW, so the shift never loses a set bit.
  assign t          = rem_i << 1;
  assign denom_ext  = {1'b0, denom_i};
  assign bit_o      = (t >= denom_ext);
  assign rem_next_o = bit_o ? (t - denom_ext) : t;

endmodule

// File: rtl/alpha_div_iter.sv
// Iterative fractional divider: alpha = floor(dark_diff * 2^QW / denom).
// One quotient bit per cycle; denom == 0 and dark_diff >= denom resolve
// in a single edge with alpha clamped to all-ones.
// Optional feature macro: ALPHA_DIV_ROUND_EN (one extra guard step, round
// half up, saturate instead of wrapping).
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake (ready only when idle)
//   dark_diff, denom      : unsigned operands
//   out_valid / out_ready : result handshake
//   alpha, sat, div_zero  : result fraction and status flags
module alpha_div_iter
  import alpha_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned QW = DefQw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dark_diff,
  input  logic [DW-1:0] denom,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] alpha,
  output logic          sat,
  output logic          div_zero
);

  localparam int unsigned CW = cnt_width(QW);
`ifdef ALPHA_DIV_ROUND_EN
  localparam int unsigned NSteps = QW + 1;
`else
  localparam int unsigned NSteps = QW;
`endif
  localparam logic [CW-1:0] LastStep = CW'(NSteps - 1);

  state_e        state_q, state_d;
  logic [DW:0]   rem_q, rem_d;
  logic [DW-1:0] denom_q, denom_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] alpha_q, alpha_d;
  logic          sat_q, sat_d;
  logic          dz_q, dz_d;

  logic          step_bit;
  logic [DW:0]   step_rem;

  alpha_div_step #(
    .DW (DW)
  ) u_step (
    .rem_i      (rem_q),
    .denom_i    (denom_q),
    .bit_o      (step_bit),
    .rem_next_o (step_rem)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    denom_d = denom_q;
    cnt_d   = cnt_q;
    alpha_d = alpha_q;
    sat_d   = sat_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          denom_d = denom;
          cnt_d   = '0;
          rem_d   = '0;
          alpha_d = '0;
          sat_d   = 1'b0;
          dz_d    = 1'b0;
          if (denom == '0) begin
            state_d = StDone;
            alpha_d = '1;
            dz_d    = 1'b1;
          end else if (dark_diff >= denom) begin
            state_d = StDone;
            alpha_d = '1;
            sat_d   = 1'b1;
          end else begin
            state_d = StBusy;
            rem_d   = {1'b0, dark_diff};
          end
        end
      end
      StBusy: begin
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
`ifdef ALPHA_DIV_ROUND_EN
        if (cnt_q == LastStep) begin
          // Guard step: the bit is not shifted in, it rounds the result.
          state_d = StDone;
          cnt_d   = '0;
          if (step_bit) begin
            if (&alpha_q) sat_d = 1'b1;
            else          alpha_d = alpha_q + QW'(1);
          end
        end else begin
          alpha_d = QW'({alpha_q, step_bit});
        end
`else
        alpha_d = QW'({alpha_q, step_bit});
        if (cnt_q == LastStep) begin
          state_d = StDone;
          cnt_d   = '0;
        end
`endif
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      denom_q <= '0;
      cnt_q   <= '0;
      alpha_q <= '0;
      sat_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      denom_q <= denom_d;
      cnt_q   <= cnt_d;
      alpha_q <= alpha_d;
      sat_q   <= sat_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign alpha     = alpha_q;
  assign sat       = sat_q;
  assign div_zero  = dz_q;

endmodule
